// File: rtl/hist_frame_seq.sv
// Frame-boundary sequencer for histogram RAM port B: dump bins into the CDF RAM, then clear them.
// Optional host single-word read port is built only when HIST_SEQ_HOST_PORT_EN is defined.
module hist_frame_seq #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync_in,
  output logic             his_rd_en,
  output logic             his_wr_en,
  output logic [7:0]       his_addr,
  input  logic [CNT_W-1:0] his_rd_data,
  output logic             cdf_wr_en,
  output logic [7:0]       cdf_addr,
  output logic [CNT_W-1:0] cdf_wr_data,
  output logic             cdf_done,
  output logic             cdf_valid,
  output logic             overrun,
  input  logic             host_req,
  input  logic [7:0]       host_addr,
  output logic             host_gnt,
  output logic             host_rd_valid,
  output logic [CNT_W-1:0] host_rd_data
);

`ifdef HIST_SEQ_HOST_PORT_EN
  typedef enum logic [1:0] {IDLE, DUMP, CLEAR, HOST} state_t;
`else
  typedef enum logic [1:0] {IDLE, DUMP, CLEAR} state_t;
`endif

  state_t           state_q;
  logic             vsync_q;
  logic             rd_en_q;
  logic             wr_en_q;
  logic [7:0]       addr_q;
  logic             rd_d1_q;
  logic [7:0]       addr_d1_q;
  logic [CNT_W-1:0] sum_q;
  logic             cdf_valid_q;
  logic             overrun_q;
  logic             gnt_q;
  logic             hvld_q;
  logic             rise;
  logic             done;

  assign rise = vsync_in & ~vsync_q;
  assign done = rd_d1_q & (addr_d1_q == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      rd_d1_q     <= 1'b0;
      addr_d1_q   <= '0;
      sum_q       <= '0;
      cdf_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      gnt_q       <= 1'b0;
      hvld_q      <= 1'b0;
    end else begin
      vsync_q   <= vsync_in;
      // RAM read data lags the address by one cycle; align the CDF write with it
      rd_d1_q   <= (state_q == DUMP);
      addr_d1_q <= (state_q == DUMP) ? addr_q : 8'd0;
      hvld_q    <= 1'b0;
      if (rd_d1_q) sum_q <= sum_q + his_rd_data;
      if (done) cdf_valid_q <= 1'b1;
      if (rise && (state_q != IDLE)) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= DUMP;
            addr_q  <= '0;
            sum_q   <= '0;
            rd_en_q <= 1'b1;
          end
`ifdef HIST_SEQ_HOST_PORT_EN
          else if (host_req) begin
            state_q <= HOST;
            addr_q  <= host_addr;
            rd_en_q <= 1'b1;
            gnt_q   <= 1'b1;
          end
`endif
        end
        DUMP: begin
          addr_q <= addr_q + 8'd1;
          if (addr_q == 8'hFF) begin
            state_q <= CLEAR;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b1;
          end
        end
        CLEAR: begin
          addr_q <= addr_q + 8'd1;
          if (addr_q == 8'hFF) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
          end
        end
`ifdef HIST_SEQ_HOST_PORT_EN
        HOST: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
          gnt_q   <= 1'b0;
          addr_q  <= '0;
          hvld_q  <= 1'b1;
        end
`endif
        default: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign his_rd_en   = rd_en_q;
  assign his_wr_en   = wr_en_q;
  assign his_addr    = addr_q;
  assign cdf_wr_en   = rd_d1_q;
  assign cdf_addr    = addr_d1_q;
  assign cdf_wr_data = rd_d1_q ? (sum_q + his_rd_data) : '0;
  assign cdf_done    = done;
  assign cdf_valid   = cdf_valid_q;
  assign overrun     = overrun_q;

`ifdef HIST_SEQ_HOST_PORT_EN
  assign host_gnt      = gnt_q;
  assign host_rd_valid = hvld_q;
  assign host_rd_data  = hvld_q ? his_rd_data : '0;
`else
  logic unused_host;
  assign unused_host   = &{1'b0, host_req, host_addr, gnt_q, hvld_q};
  assign host_gnt      = 1'b0;
  assign host_rd_valid = 1'b0;
  assign host_rd_data  = '0;
`endif

endmodule

// File: tb/tb_hist_frame_seq.sv
// Bench for hist_frame_seq: histogram RAM model, event logs, and a CDF reference computed from bin snapshots.
module tb_hist_frame_seq;
  localparam int CNT_W = 19;
  localparam int L     = 4096;
  localparam int MASK  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, vsync_in, his_rd_en, his_wr_en, cdf_wr_en, cdf_done, cdf_valid, overrun;
  logic [7:0]       his_addr, cdf_addr, host_addr;
  logic [CNT_W-1:0] his_rd_data, cdf_wr_data, host_rd_data;
  logic             host_req, host_gnt, host_rd_valid;

  always #5 clk = ~clk;

  hist_frame_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in),
    .his_rd_en(his_rd_en), .his_wr_en(his_wr_en), .his_addr(his_addr), .his_rd_data(his_rd_data),
    .cdf_wr_en(cdf_wr_en), .cdf_addr(cdf_addr), .cdf_wr_data(cdf_wr_data),
    .cdf_done(cdf_done), .cdf_valid(cdf_valid), .overrun(overrun),
    .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
    .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data)
  );

  // Histogram RAM port B plus a bulk-load path standing in for the pixel-accumulation side
  logic [CNT_W-1:0] hist      [0:255];
  logic [CNT_W-1:0] hist_init [0:255];
  logic             ld_all;
  logic [CNT_W-1:0] rd_data_q = '0;
  assign his_rd_data = rd_data_q;

  always @(posedge clk) begin
    if (ld_all) begin
      for (int k = 0; k < 256; k++) hist[k] <= hist_init[k];
    end else if (his_wr_en) begin
      hist[his_addr] <= '0;
    end
    if (his_rd_en) rd_data_q <= hist[his_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]       rd_addr_log [0:L-1];
  int               rd_cyc_log  [0:L-1];
  logic [7:0]       wr_addr_log [0:L-1];
  int               wr_cyc_log  [0:L-1];
  logic [7:0]       cdf_addr_log[0:L-1];
  logic [CNT_W-1:0] cdf_data_log[0:L-1];
  int               cdf_cyc_log [0:L-1];
  int               done_cyc_log[0:L-1];
  int               gnt_cyc_log [0:L-1];
  int rd_n = 0, wr_n = 0, cdf_n = 0, done_n = 0, gnt_n = 0, hv_n = 0;

  always @(negedge clk) begin
    if (his_rd_en === 1'b1) begin
      rd_addr_log[rd_n % L] = his_addr; rd_cyc_log[rd_n % L] = cyc; rd_n++;
    end
    if (his_wr_en === 1'b1) begin
      wr_addr_log[wr_n % L] = his_addr; wr_cyc_log[wr_n % L] = cyc; wr_n++;
    end
    if (cdf_wr_en === 1'b1) begin
      cdf_addr_log[cdf_n % L] = cdf_addr; cdf_data_log[cdf_n % L] = cdf_wr_data;
      cdf_cyc_log[cdf_n % L] = cyc; cdf_n++;
    end
    if (cdf_done === 1'b1) begin
      done_cyc_log[done_n % L] = cyc; done_n++;
    end
    if (host_gnt === 1'b1) begin
      gnt_cyc_log[gnt_n % L] = cyc; gnt_n++;
    end
    if (host_rd_valid === 1'b1) hv_n++;
  end

  int errors = 0, checks = 0;
  int snap [0:255];
  int exp_cdf [0:255];
  int s_rd, s_wr, s_cdf, s_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load();
    ld_all = 1'b1;
    tick();
    ld_all = 1'b0;
  endtask

  // CDF reference: running sum of the bin snapshot taken at the frame boundary
  task automatic start_seq(output int n);
    int acc;
    acc = 0;
    for (int k = 0; k < 256; k++) begin
      snap[k]    = int'(hist[k]);
      acc        = (acc + snap[k]) & MASK;
      exp_cdf[k] = acc;
    end
    s_rd = rd_n; s_wr = wr_n; s_cdf = cdf_n; s_done = done_n;
    vsync_in = 1'b1;
    n = cyc + 1;
    tick();
    tick();
    vsync_in = 1'b0;
  endtask

  task automatic finish_seq(input int n);
    int cnt, bad, c, z;
    while (cyc < n + 512) tick();
    cnt = 0; bad = 0;
    for (int i = s_rd; i < rd_n; i++) begin
      c = rd_cyc_log[i % L];
      if (c >= n && c < n + 512) begin
        if (rd_addr_log[i % L] != 8'(cnt) || c != n + cnt) bad++;
        cnt++;
      end
    end
    check("dump_reads", cnt, 256);
    check("dump_order", bad, 0);
    cnt = 0; bad = 0;
    for (int i = s_wr; i < wr_n; i++) begin
      if (wr_addr_log[i % L] != 8'(cnt) || wr_cyc_log[i % L] != n + 256 + cnt) bad++;
      cnt++;
    end
    check("clear_writes", cnt, 256);
    check("clear_order", bad, 0);
    cnt = 0; bad = 0;
    for (int i = s_cdf; i < cdf_n; i++) begin
      if (cnt > 255 || cdf_addr_log[i % L] != 8'(cnt) || cdf_cyc_log[i % L] != n + 1 + cnt ||
          int'(cdf_data_log[i % L]) != exp_cdf[cnt & 255]) bad++;
      cnt++;
    end
    check("cdf_writes", cnt, 256);
    check("cdf_values", bad, 0);
    check("cdf_entry255", cdf_data_log[(s_cdf + 255) % L], exp_cdf[255]);
    check("done_count", done_n - s_done, 1);
    check("done_cycle", done_cyc_log[s_done % L], n + 256);
    check("cdf_valid_set", cdf_valid, 1);
    check("idle_after_seq", {his_rd_en, his_wr_en}, 0);
    z = 0;
    for (int k = 0; k < 256; k++) if (hist[k] != '0) z++;
    check("ram_cleared", z, 0);
  endtask

  initial begin
    int n, g, r, hv, m, a;
    rst_n = 1'b0; vsync_in = 1'b0; host_req = 1'b0; host_addr = '0; ld_all = 1'b0;
    for (int k = 0; k < 256; k++) hist_init[k] = '0;
    repeat (3) tick();
    check("rst_enables", {his_rd_en, his_wr_en, cdf_wr_en, cdf_done}, 0);
    check("rst_sticky", {cdf_valid, overrun}, 0);
    check("rst_cdf_bus", {cdf_addr, cdf_wr_data}, 0);
    check("rst_host", {host_gnt, host_rd_valid, host_rd_data}, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Ramp: bin k holds k
    for (int k = 0; k < 256; k++) hist_init[k] = CNT_W'(k);
    load();
    start_seq(n);
    finish_seq(n);
    check("ramp_cdf255", exp_cdf[255], 32640);
    check("ramp_no_overrun", overrun, 0);

    // All 10000 pixels in bin 37
    for (int k = 0; k < 256; k++) hist_init[k] = '0;
    hist_init[37] = CNT_W'(10000);
    load();
    start_seq(n);
    finish_seq(n);
    check("single_cdf36", cdf_data_log[(s_cdf + 36) % L], 0);
    check("single_cdf37", cdf_data_log[(s_cdf + 37) % L], 10000);
    check("single_cdf255", cdf_data_log[(s_cdf + 255) % L], 10000);

    // Random bins, total stays below 2^CNT_W
    for (int k = 0; k < 256; k++) hist_init[k] = CNT_W'($urandom_range(0, 2000));
    load();
    start_seq(n);
    finish_seq(n);

    // Host reads
    for (int k = 0; k < 256; k++) hist_init[k] = CNT_W'($urandom_range(0, 2000));
    hist_init[8'h12] = CNT_W'(555);
    load();
    tick();
`ifdef HIST_SEQ_HOST_PORT_EN
    for (int t = 0; t < 4; t++) begin
      a = (t == 0) ? 8'h12 : int'($urandom_range(0, 255));
      host_addr = 8'(a); host_req = 1'b1;
      m = cyc + 1; g = gnt_n;
      for (int w = 0; w < 20 && gnt_n == g; w++) tick();
      check("host_gnt_seen", gnt_n - g, 1);
      check("host_gnt_cycle", gnt_cyc_log[g % L], m);
      host_req = 1'b0;
      tick();
      check("host_rd_valid", host_rd_valid, 1);
      check("host_rd_data", host_rd_data, hist_init[a]);
      tick();
      check("host_single_grant", {host_gnt, host_rd_valid}, 0);
    end
    host_addr = 8'h05; host_req = 1'b1; g = gnt_n;
    for (int w = 0; w < 20 && gnt_n < g + 2; w++) tick();
    host_req = 1'b0;
    check("host_regrant_gap", gnt_cyc_log[(g + 1) % L] - gnt_cyc_log[g % L], 2);
    repeat (3) tick();
`else
    g = gnt_n; hv = hv_n; r = rd_n;
    host_addr = 8'h12; host_req = 1'b1;
    repeat (20) tick();
    host_req = 1'b0;
    check("nohost_gnt", gnt_n - g, 0);
    check("nohost_valid", hv_n - hv, 0);
    check("nohost_reads", rd_n - r, 0);
`endif

    // Collision: vsync rise and host request in the same IDLE cycle
    host_addr = 8'h12; host_req = 1'b1; g = gnt_n;
    start_seq(n);
    finish_seq(n);
    for (int w = 0; w < 10 && gnt_n == g; w++) tick();
`ifdef HIST_SEQ_HOST_PORT_EN
    check("collide_gnt_count", gnt_n - g, 1);
    check("collide_gnt_cycle", gnt_cyc_log[g % L], n + 513);
    host_req = 1'b0;
    tick();
    check("collide_rd_data", {host_rd_valid, host_rd_data}, {1'b1, CNT_W'(0)});
`else
    check("collide_gnt_count", gnt_n - g, 0);
    host_req = 1'b0;
`endif
    check("collide_no_overrun", overrun, 0);
    repeat (3) tick();

    // Overrun: second rise 100 cycles into DUMP is ignored
    for (int k = 0; k < 256; k++) hist_init[k] = CNT_W'($urandom_range(0, 2000));
    load();
    start_seq(n);
    while (cyc < n + 99) tick();
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    tick();
    check("overrun_set", overrun, 1);
    finish_seq(n);
    r = rd_n;
    repeat (20) tick();
    check("overrun_no_restart", rd_n - r, 0);
    check("overrun_sticky", overrun, 1);

    // Reset during CLEAR at address 80
    for (int k = 0; k < 256; k++) hist_init[k] = CNT_W'($urandom_range(1, 2000));
    load();
    start_seq(n);
    while (cyc < n + 336) tick();
    check("clear_at_80", {his_wr_en, his_addr}, {1'b1, 8'd80});
    rst_n = 1'b0;
    #1;
    check("midrst_enables", {his_rd_en, his_wr_en, cdf_wr_en, cdf_done, his_addr}, 0);
    check("midrst_sticky", {cdf_valid, overrun}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    r = rd_n;
    repeat (5) tick();
    check("midrst_idle", rd_n - r, 0);
    check("midrst_bin80_kept", hist[80], hist_init[80]);
    start_seq(n);
    while (cyc < n + 200) tick();
    check("cdf_valid_low_until_done", cdf_valid, 0);
    finish_seq(n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
